// File: rtl/exmem_skid.sv
// -----------------------------------------------------------------------------
// exmem_skid
//
// Two-entry in-order skid buffer that holds EX/MEM pipeline register contents.
// The EX stage pushes one instruction per cycle when in_ready is high. The MEM
// stage pops the head entry when it raises out_ready. Because in_ready depends
// only on the registered entry count, a MEM stall reaches the ID/EX and EX
// stall logic one cycle later. The second entry absorbs the instruction that is
// already in flight during that cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. in_ready/in_valid govern the push side and out_valid/out_ready govern the
// pop side. in_ready never depends combinationally on out_ready.
//
// Parameters
//   DATA_W         width of the ALU result and store-data fields
//   PC_W           width of the pc1 field
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       EX presents a valid instruction
//   in_ready       buffer can accept (count != 2)
//   alu_result     EX ALU result
//   store_data     EX store data
//   flagsMEM       MEM-stage control flags
//   flagsWB        WB-stage control flags
//   rd             destination register
//   pc1            PC + 1 of the instruction
//   flush          synchronous discard of all held entries
//   out_ready      MEM accepts the head entry
//   out_valid      head entry is valid (count != 0)
//   out_*          head entry fields
//   occupancy      number of held entries (0..2), which is also the FSM state
//   stall_cycles   saturating count of cycles with out_valid=1 and out_ready=0
// -----------------------------------------------------------------------------
module exmem_skid #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [2:0]        flagsMEM,
    input  logic [1:0]        flagsWB,
    input  logic [4:0]        rd,
    input  logic [PC_W-1:0]   pc1,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [2:0]        out_flagsMEM,
    output logic [1:0]        out_flagsWB,
    output logic [4:0]        out_rd,
    output logic [PC_W-1:0]   out_pc1,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cycles
);

    // One entry packs every carried field. The field order is
    // {alu_result, store_data, flagsMEM, flagsWB, rd, pc1}.
    localparam int ENT_W = 2 * DATA_W + 3 + 2 + 5 + PC_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ENT_W-1:0]   r_head;
    logic [ENT_W-1:0]   r_tail;
    logic [15:0]        r_stall_cycles;

    logic [ENT_W-1:0]   w_in_entry;
    logic               w_push;
    logic               w_pop;
    logic               w_load_head_in;
    logic               w_load_head_tail;
    logic               w_load_tail_in;
    logic               w_backpressure;

    assign w_in_entry = {alu_result, store_data, flagsMEM, flagsWB, rd, pc1};

    // Handshake qualifiers. Both sides use the registered state, so out_ready
    // only reaches the register inputs.
    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic. Flush wins over any push or pop in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_push && !w_pop) begin
                        w_state_nxt = S_TWO;
                    end else if (w_pop && !w_push) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so the only possible move is a pop.
                    if (w_pop) begin
                        w_state_nxt = S_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs decoded from the registered state only
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state != S_TWO);
        out_valid = (r_state != S_EMPTY);
        occupancy = r_state;
    end

    // -------------------------------------------------------------------------
    // Entry data path
    //
    // New data goes to head when the buffer is empty, or when it holds one
    // entry that is popped in the same cycle. New data goes to tail when one
    // entry is held and none leaves. A pop from two entries moves tail into
    // head. In every other case, including flush, the entries keep their
    // contents and only the count changes.
    // -------------------------------------------------------------------------
    assign w_load_head_in   = !flush && w_push &&
                              ((r_state == S_EMPTY) || ((r_state == S_ONE) && w_pop));
    assign w_load_head_tail = !flush && w_pop && (r_state == S_TWO);
    assign w_load_tail_in   = !flush && w_push && (r_state == S_ONE) && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
        end else if (w_load_head_in) begin
            r_head <= w_in_entry;
        end else if (w_load_head_tail) begin
            r_head <= r_tail;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tail <= '0;
        end else if (w_load_tail_in) begin
            r_tail <= w_in_entry;
        end
    end

    assign {out_alu_result, out_store_data, out_flagsMEM,
            out_flagsWB, out_rd, out_pc1} = r_head;

    // -------------------------------------------------------------------------
    // MEM-side back-pressure counter. It saturates instead of wrapping, and
    // flush leaves it alone so that stall statistics survive pipeline flushes.
    // -------------------------------------------------------------------------
    assign w_backpressure = out_valid & ~out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 16'd0;
        end else if (w_backpressure && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_exmem_skid.sv
module tb_exmem_skid;

  localparam int DATA_W = 32;
  localparam int PC_W   = 48;
  localparam int ENT_W  = 2 * DATA_W + 3 + 2 + 5 + PC_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [2:0]        flagsMEM;
  logic [1:0]        flagsWB;
  logic [4:0]        rd;
  logic [PC_W-1:0]   pc1;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_store_data;
  logic [2:0]        out_flagsMEM;
  logic [1:0]        out_flagsWB;
  logic [4:0]        out_rd;
  logic [PC_W-1:0]   out_pc1;
  logic [1:0]        occupancy;
  logic [15:0]       stall_cycles;

  exmem_skid #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_result     (alu_result),
    .store_data     (store_data),
    .flagsMEM       (flagsMEM),
    .flagsWB        (flagsWB),
    .rd             (rd),
    .pc1            (pc1),
    .flush          (flush),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_alu_result (out_alu_result),
    .out_store_data (out_store_data),
    .out_flagsMEM   (out_flagsMEM),
    .out_flagsWB    (out_flagsWB),
    .out_rd         (out_rd),
    .out_pc1        (out_pc1),
    .occupancy      (occupancy),
    .stall_cycles   (stall_cycles)
  );

  // ---------------- scoreboard ----------------
  logic [ENT_W-1:0] exp_q[$];
  logic [15:0]      exp_stall;
  int               total;
  int               bad;
  bit               check_en;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ENT_W-1:0] out_entry();
    return {out_alu_result, out_store_data, out_flagsMEM, out_flagsWB, out_rd, out_pc1};
  endfunction

  function automatic logic [ENT_W-1:0] in_entry();
    return {alu_result, store_data, flagsMEM, flagsWB, rd, pc1};
  endfunction

  task automatic check_outputs(input string tag);
    int sz;
    sz = exp_q.size();
    check({tag, ".out_valid"}, 128'(out_valid), 128'(sz != 0));
    check({tag, ".in_ready"}, 128'(in_ready), 128'(sz != 2));
    check({tag, ".occupancy"}, 128'(occupancy), 128'(sz));
    check({tag, ".stall"}, 128'(stall_cycles), 128'(exp_stall));
    if (sz != 0) check({tag, ".head"}, 128'(out_entry()), 128'(exp_q[0]));
  endtask

  // Check the current outputs, advance the reference model with the inputs
  // driven now, then move to 1 time unit after the next rising edge.
  task automatic cyc(input string tag);
    int  sz;
    bit  push;
    bit  pop;
    if (check_en) check_outputs(tag);
    sz = exp_q.size();
    if (sz != 0 && !out_ready && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    if (flush) begin
      exp_q.delete();
    end else begin
      pop  = (sz != 0) && out_ready;
      push = in_valid && (sz != 2);
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(in_entry());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] r,
                       input logic ordy, input logic fl);
    in_valid   = v;
    alu_result = alu;
    rd         = r;
    out_ready  = ordy;
    flush      = fl;
    store_data = $urandom();
    flagsMEM   = 3'($urandom_range(0, 7));
    flagsWB    = 2'($urandom_range(0, 3));
    pc1        = {16'($urandom()), $urandom()};
  endtask

  task automatic drive_random();
    drive(1'($urandom_range(0, 1)), $urandom(), 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    total     = 0;
    bad       = 0;
    exp_stall = 16'd0;
    check_en  = 1'b1;
    rst_n     = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);

    // Reset state
    #12;
    check_outputs("reset");
    check("reset.out_data", 128'(out_entry()), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single transfer
    drive(1'b1, 32'h0000_00AA, 5'd3, 1'b1, 1'b0);
    cyc("single.push");
    drive(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
    check("single.rd", 128'(out_rd), 128'(5'd3));
    check("single.alu", 128'(out_alu_result), 128'(32'hAA));
    cyc("single.head");
    cyc("single.empty");
    check("single.occ0", 128'(occupancy), 128'd0);

    // Fill and back-pressure: A, B accepted, C refused
    drive(1'b1, 32'd1, 5'd1, 1'b0, 1'b0);
    cyc("fill.A");
    drive(1'b1, 32'd2, 5'd2, 1'b0, 1'b0);
    cyc("fill.B");
    drive(1'b1, 32'd3, 5'd3, 1'b0, 1'b0);
    check("fill.in_ready0", 128'(in_ready), 128'd0);
    cyc("fill.C1");
    cyc("fill.C2");
    check("fill.occ2", 128'(occupancy), 128'd2);
    drive(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
    check("fill.headA", 128'(out_alu_result), 128'd1);
    cyc("drain.A");
    check("fill.headB", 128'(out_alu_result), 128'd2);
    cyc("drain.B");
    cyc("drain.empty");

    // Simultaneous push and pop at one entry
    drive(1'b1, 32'd5, 5'd5, 1'b0, 1'b0);
    cyc("pp.push5");
    drive(1'b1, 32'd6, 5'd6, 1'b1, 1'b0);
    cyc("pp.push6pop5");
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
    check("pp.occ1", 128'(occupancy), 128'd1);
    check("pp.head6", 128'(out_alu_result), 128'd6);
    cyc("pp.hold");

    // Flush priority over a same-cycle push, stall count retained
    drive(1'b1, 32'd7, 5'd7, 1'b0, 1'b0);
    cyc("fl.fill");
    drive(1'b1, 32'd8, 5'd8, 1'b0, 1'b1);
    cyc("fl.flush");
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
    check("fl.occ0", 128'(occupancy), 128'd0);
    check("fl.in_ready1", 128'(in_ready), 128'd1);
    cyc("fl.after");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cyc("rand");
    end

    // Saturation with one held entry
    drive(1'b0, 32'd0, 5'd0, 1'b1, 1'b1);
    cyc("sat.flush");
    drive(1'b1, 32'h1234, 5'd9, 1'b0, 1'b0);
    cyc("sat.push");
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
    check_en = 1'b0;
    for (int i = 0; i < 70000; i++) cyc("sat");
    check_en = 1'b1;
    check_outputs("sat.end");
    check("sat.ffff", 128'(stall_cycles), 128'(16'hFFFF));

    // Reset in the middle of a cycle
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    exp_stall = 16'd0;
    #1;
    check_outputs("mid_reset");
    check("mid_reset.out_data", 128'(out_entry()), 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 32'hBEEF, 5'd17, 1'b0, 1'b0);
    cyc("post_reset.push");
    drive(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
    check("post_reset.head", 128'(out_alu_result), 128'(32'hBEEF));
    cyc("post_reset.pop");
    cyc("post_reset.empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
